qec_pulse_sequencer: RTL and testbench

Bus initiator that drives the qubit-grid register interface from the controller side. Once started, it configures pulse strength, enables the physics engines, then repeatedly samples the syndrome register and sustains correction pulses on the errored qubits. The sequencer sits between the RISC-V control core's start/stop strobes and the grid's `cs/we/addr/wdata/rdata` port. It replaces software polling loops, which cannot hold pulse writes on every cycle.

---
 rtl/qcu_grid_pkg.sv | 37 +++
 rtl/syndrome_vote.sv | 39 +++
 rtl/qec_pulse_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_qec_pulse_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/qcu_grid_pkg.sv
// Shared definitions for the qubit-grid register interface and its pulse sequencer:
// register map, sequencer state encoding, bus request payload and counter helper.
package qcu_grid_pkg;

  localparam int unsigned NUM_QUBITS = 9;
  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CNT_W      = 16;

  localparam logic [ADDR_W-1:0] REG_CTRL     = 4'd0;
  localparam logic [ADDR_W-1:0] REG_PULSE    = 4'd1;
  localparam logic [ADDR_W-1:0] REG_SYND     = 4'd2;
  localparam logic [ADDR_W-1:0] REG_STRENGTH = 4'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CFG_STR = 3'd1,
    ST_CFG_EN  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_SAMPLE  = 3'd4,
    ST_PULSE   = 3'd5,
    ST_DISABLE = 3'd6
  } seq_state_t;

  typedef struct packed {
    logic              cs;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/syndrome_vote.sv
// Three-read syndrome vote: shifts in the first two reads, votes them against the live
// third read. Only present in builds with QCU_SEQ_VOTE_EN defined.
`ifdef QCU_SEQ_VOTE_EN
module syndrome_vote
  import qcu_grid_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  shift_en,
  input  logic [NUM_QUBITS-1:0] din,
  output logic [NUM_QUBITS-1:0] mask_c
);

  logic [NUM_QUBITS-1:0] s0_q, s0_d;
  logic [NUM_QUBITS-1:0] s1_q, s1_d;

  always_comb begin
    s0_d = s0_q;
    s1_d = s1_q;
    if (shift_en) begin
      s1_d = s0_q;
      s0_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_q <= '0;
      s1_q <= '0;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
    end
  end

  assign mask_c = (din & s0_q) | (din & s1_q) | (s0_q & s1_q);

endmodule
`endif

// File: rtl/qec_pulse_sequencer.sv
// Bus initiator: configures the qubit grid, periodically samples the syndrome and holds
// correction pulses. Define QCU_SEQ_VOTE_EN for a 2-of-3 majority over three syndrome reads.
module qec_pulse_sequencer
  import qcu_grid_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES    = 16,
  parameter int unsigned SAMPLE_INTERVAL = 64,
  parameter logic [15:0] PULSE_STRENGTH  = 16'd500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  output logic                  busy,
  output logic [NUM_QUBITS-1:0] last_syndrome,
  output logic [CNT_W-1:0]      round_count,
  output logic [CNT_W-1:0]      corr_count,
  output logic                  bus_cs,
  output logic                  bus_we,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic [DATA_W-1:0]     bus_rdata
);

  localparam int unsigned WAIT_W  = $clog2(SAMPLE_INTERVAL + 1);
  localparam int unsigned PULSE_W = 8;
  localparam logic [WAIT_W-1:0]  WAIT_LOAD  = WAIT_W'(SAMPLE_INTERVAL - 1);
  localparam logic [PULSE_W-1:0] PULSE_LOAD = PULSE_W'(PULSE_CYCLES - 1);

  seq_state_t            state_q, state_d;
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [PULSE_W-1:0]    pulse_cnt_q, pulse_cnt_d;
  logic [NUM_QUBITS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]      round_q, round_d;
  logic [CNT_W-1:0]      corr_q, corr_d;
  bus_req_t              bus_q, bus_d;
  logic                  busy_q, busy_d;

  logic [NUM_QUBITS-1:0] sample_mask_c;
  logic                  sample_done_c;
  logic                  sample_abort_c;
  logic                  unused_rdata_c;

  assign unused_rdata_c = ^bus_rdata[DATA_W-1:NUM_QUBITS];

`ifdef QCU_SEQ_VOTE_EN
  logic [1:0] vote_idx_q, vote_idx_d;

  syndrome_vote u_vote (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (state_q == ST_SAMPLE),
    .din      (bus_rdata[NUM_QUBITS-1:0]),
    .mask_c   (sample_mask_c)
  );

  // Read index within a vote; held at zero outside SAMPLE so every vote starts fresh.
  always_comb begin
    vote_idx_d = 2'd0;
    if (state_q == ST_SAMPLE) vote_idx_d = vote_idx_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) vote_idx_q <= 2'd0;
    else        vote_idx_q <= vote_idx_d;
  end

  assign sample_done_c  = (vote_idx_q == 2'd2);
  assign sample_abort_c = stop;
`else
  assign sample_mask_c  = bus_rdata[NUM_QUBITS-1:0];
  assign sample_done_c  = 1'b1;
  assign sample_abort_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      pulse_cnt_q <= '0;
      mask_q      <= '0;
      round_q     <= '0;
      corr_q      <= '0;
      bus_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      mask_q      <= mask_d;
      round_q     <= round_d;
      corr_q      <= corr_d;
      bus_q       <= bus_d;
      busy_q      <= busy_d;
    end
  end

  // Next state, counter reloads and statistics.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    mask_d      = mask_q;
    round_d     = round_q;
    corr_d      = corr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_CFG_STR;
          round_d = '0;
          corr_d  = '0;
        end
      end
      ST_CFG_STR: state_d = stop ? ST_DISABLE : ST_CFG_EN;
      ST_CFG_EN: begin
        if (stop) begin
          state_d = ST_DISABLE;
        end else begin
          state_d    = ST_WAIT;
          wait_cnt_d = WAIT_LOAD;
        end
      end
      ST_WAIT: begin
        if (stop)                  state_d = ST_DISABLE;
        else if (wait_cnt_q == '0) state_d = ST_SAMPLE;
        else                       wait_cnt_d = wait_cnt_q - WAIT_W'(1);
      end
      ST_SAMPLE: begin
        if (sample_abort_c) begin
          state_d = ST_DISABLE;
        end else if (sample_done_c) begin
          mask_d  = sample_mask_c;
          round_d = sat_inc(round_q);
          if (|sample_mask_c) begin
            corr_d      = sat_inc(corr_q);
            state_d     = ST_PULSE;
            pulse_cnt_d = PULSE_LOAD;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end
          if (stop) state_d = ST_DISABLE;
        end
      end
      ST_PULSE: begin
        if (stop) begin
          state_d = ST_DISABLE;
        end else if (pulse_cnt_q == '0) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WAIT_LOAD;
        end else begin
          pulse_cnt_d = pulse_cnt_q - PULSE_W'(1);
        end
      end
      ST_DISABLE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Bus request for the state being entered, so the registered bus lines up with state_q.
  always_comb begin
    bus_d  = '0;
    busy_d = (state_d != ST_IDLE);
    unique case (state_d)
      ST_CFG_STR: bus_d = '{cs: 1'b1, we: 1'b1, addr: REG_STRENGTH, wdata: DATA_W'(PULSE_STRENGTH)};
      ST_CFG_EN:  bus_d = '{cs: 1'b1, we: 1'b1, addr: REG_CTRL,     wdata: DATA_W'(1)};
      ST_SAMPLE:  bus_d = '{cs: 1'b1, we: 1'b0, addr: REG_SYND,     wdata: '0};
      ST_PULSE:   bus_d = '{cs: 1'b1, we: 1'b1, addr: REG_PULSE,    wdata: DATA_W'(mask_d)};
      ST_DISABLE: bus_d = '{cs: 1'b1, we: 1'b1, addr: REG_CTRL,     wdata: '0};
      default:    bus_d = '0;
    endcase
  end

  assign busy          = busy_q;
  assign last_syndrome = mask_q;
  assign round_count   = round_q;
  assign corr_count    = corr_q;
  assign bus_cs        = bus_q.cs;
  assign bus_we        = bus_q.we;
  assign bus_addr      = bus_q.addr;
  assign bus_wdata     = bus_q.wdata;

endmodule

// File: tb/tb_qec_pulse_sequencer.sv
// Self-checking bench for qec_pulse_sequencer: per-cycle vector table for a full run plus
// directed stop, reset-mid-run and (with QCU_SEQ_VOTE_EN) majority-vote sequences.
module tb_qec_pulse_sequencer;

`ifdef QCU_SEQ_VOTE_EN
  localparam int E = 2;
`else
  localparam int E = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, stop;
  logic        busy;
  logic [8:0]  last_syndrome;
  logic [15:0] round_count, corr_count;
  logic        bus_cs, bus_we;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;

  always #5 clk = ~clk;

  qec_pulse_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stop          (stop),
    .busy          (busy),
    .last_syndrome (last_syndrome),
    .round_count   (round_count),
    .corr_count    (corr_count),
    .bus_cs        (bus_cs),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_rdata     (bus_rdata)
  );

  // Responder: SYND reads return synd_seq[rd_ph], rd_ph steps per completed read.
  logic [8:0] synd_seq [3];
  logic [1:0] rd_ph;
  int         pulse_wr;
  logic       rd_now;

  assign rd_now    = bus_cs && !bus_we && (bus_addr == 4'd2);
  assign bus_rdata = rd_now ? {23'd0, synd_seq[rd_ph]} : 32'd0;

  always @(posedge clk) begin
    if (!rst_n) begin
      rd_ph    <= 2'd0;
      pulse_wr <= 0;
    end else begin
      if (rd_now) rd_ph <= (rd_ph == 2'd2) ? 2'd0 : rd_ph + 2'd1;
      if (bus_cs && bus_we && bus_addr == 4'd1) pulse_wr <= pulse_wr + 1;
    end
  end

  int checks   = 0;
  int failures = 0;
  int k;

  typedef struct {
    int          k;
    logic [8:0]  synd;
    logic        st;
    logic [37:0] bus;
    logic [41:0] stat;
  } vec_t;

  vec_t tab [14];

  function automatic logic [37:0] bv(input logic cs, input logic we, input logic [3:0] a,
                                     input logic [31:0] d);
    return {cs, we, a, d};
  endfunction

  function automatic logic [41:0] sv(input logic b, input logic [8:0] l, input logic [15:0] r,
                                     input logic [15:0] c);
    return {b, l, r, c};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", name, k, act, exp);
    end
  endtask

  task automatic chk_bus(input string name, input logic [37:0] exp);
    chk({name, " bus"}, 64'({bus_cs, bus_we, bus_addr, bus_wdata}), 64'(exp));
  endtask

  task automatic chk_stat(input string name, input logic [41:0] exp);
    chk({name, " status"}, 64'({busy, last_syndrome, round_count, corr_count}), 64'(exp));
  endtask

  task automatic advance();
    @(negedge clk);
    k++;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic goto(input int target);
    while (k < target) advance();
  endtask

  task automatic set_synd(input logic [8:0] v);
    synd_seq[0] = v;
    synd_seq[1] = v;
    synd_seq[2] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    k = 0;
    advance();
  endtask

  initial begin
    set_synd(9'h000);
    do_reset();
    k = 0;
    chk_bus("reset", bv(0, 0, 0, 0));
    chk_stat("reset", sv(0, 0, 0, 0));

    tab[0]  = '{1,         9'h105, 0, bv(1, 1, 3, 500),       sv(1, 9'h000, 0, 0)};
    tab[1]  = '{2,         9'h105, 0, bv(1, 1, 0, 1),         sv(1, 9'h000, 0, 0)};
    tab[2]  = '{3,         9'h105, 0, bv(0, 0, 0, 0),         sv(1, 9'h000, 0, 0)};
    tab[3]  = '{66,        9'h105, 0, bv(0, 0, 0, 0),         sv(1, 9'h000, 0, 0)};
    tab[4]  = '{67,        9'h105, 0, bv(1, 0, 2, 0),         sv(1, 9'h000, 0, 0)};
    tab[5]  = '{68 + E,    9'h105, 0, bv(1, 1, 1, 32'h105),   sv(1, 9'h105, 1, 1)};
    tab[6]  = '{83 + E,    9'h105, 0, bv(1, 1, 1, 32'h105),   sv(1, 9'h105, 1, 1)};
    tab[7]  = '{84 + E,    9'h105, 1, bv(0, 0, 0, 0),         sv(1, 9'h105, 1, 1)};
    tab[8]  = '{147 + E,   9'h000, 0, bv(0, 0, 0, 0),         sv(1, 9'h105, 1, 1)};
    tab[9]  = '{148 + E,   9'h000, 0, bv(1, 0, 2, 0),         sv(1, 9'h105, 1, 1)};
    tab[10] = '{149 + 2*E, 9'h000, 0, bv(0, 0, 0, 0),         sv(1, 9'h000, 2, 1)};
    tab[11] = '{212 + 2*E, 9'h000, 0, bv(0, 0, 0, 0),         sv(1, 9'h000, 2, 1)};
    tab[12] = '{213 + 2*E, 9'h000, 0, bv(1, 0, 2, 0),         sv(1, 9'h000, 2, 1)};
    tab[13] = '{214 + 3*E, 9'h000, 0, bv(0, 0, 0, 0),         sv(1, 9'h000, 3, 1)};

    do_start();
    for (int i = 0; i < 14; i++) begin
      goto(tab[i].k);
      chk_bus($sformatf("vec%0d", i), tab[i].bus);
      chk_stat($sformatf("vec%0d", i), tab[i].stat);
      set_synd(tab[i].synd);
      start = tab[i].st;
    end
    chk("run pulse writes", 64'(pulse_wr), 64'd16);

    // stop on the 5th pulse cycle truncates the burst and issues the disable write
    do_reset();
    set_synd(9'h105);
    do_start();
    goto(72 + E);
    chk_bus("stop 5th pulse", bv(1, 1, 1, 32'h105));
    stop = 1'b1;
    advance();
    chk_bus("stop disable", bv(1, 1, 0, 0));
    chk_stat("stop disable", sv(1, 9'h105, 1, 1));
    advance();
    chk_bus("stop idle", bv(0, 0, 0, 0));
    chk_stat("stop idle", sv(0, 9'h105, 1, 1));
    chk("stop pulse writes", 64'(pulse_wr), 64'd5);

    // start and stop together in IDLE: stop wins
    start = 1'b1;
    stop  = 1'b1;
    advance();
    chk_bus("start+stop idle", bv(0, 0, 0, 0));
    chk_stat("start+stop idle", sv(0, 9'h105, 1, 1));

    // reset mid-pulse: bus drops at the next edge, no disable write, start under reset ignored
    do_start();
    goto(70 + E);
    chk_bus("pre-reset pulse", bv(1, 1, 1, 32'h105));
    rst_n = 1'b0;
    start = 1'b1;
    advance();
    chk_bus("reset mid-run", bv(0, 0, 0, 0));
    chk_stat("reset mid-run", sv(0, 9'h000, 0, 0));
    start = 1'b1;
    advance();
    rst_n = 1'b1;
    advance();
    chk_bus("after reset", bv(0, 0, 0, 0));
    chk_stat("after reset", sv(0, 9'h000, 0, 0));

`ifdef QCU_SEQ_VOTE_EN
    do_reset();
    synd_seq[0] = 9'h003;
    synd_seq[1] = 9'h006;
    synd_seq[2] = 9'h002;
    do_start();
    for (int c = 67; c <= 69; c++) begin
      goto(c);
      chk_bus($sformatf("vote read%0d", c - 67), bv(1, 0, 2, 0));
      chk_stat($sformatf("vote read%0d", c - 67), sv(1, 9'h000, 0, 0));
    end
    goto(70);
    chk_bus("vote pulse first", bv(1, 1, 1, 32'h002));
    chk_stat("vote pulse first", sv(1, 9'h002, 1, 1));
    goto(85);
    chk_bus("vote pulse last", bv(1, 1, 1, 32'h002));
    goto(86);
    chk_bus("vote wait", bv(0, 0, 0, 0));
    chk("vote pulse writes", 64'(pulse_wr), 64'd16);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
